// File: rtl/br_commit_tracker.sv
// Branch commit tracker: carries fetch-time predictor metadata down IF/ID,
// ID/EX and EX/MEM, merges EX resolution, drives BTB/PHT update fields and
// keeps committed control-transfer and misprediction counters.
//
// Ports:
//   clk_i, rst_i             clock, async active-low reset
//   IF_*_i                   fetch-time valid / pc / BTB hit / prediction
//   stall_i, flush_i         load-use stall, wrong-path flush
//   EX_*_i                   EX-stage branch type, decision, target
//   clr_cnt_i                synchronous counter clear
//   EXMEM_*_o                committed entry for the predictor update
//   br_cnt_o, mispred_cnt_o  saturating performance counters

module br_commit_tracker #(
    parameter int INDEX_WIDTH = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    IF_valid_i,
    input  logic [31:0]             IF_pc_i,
    input  logic                    IF_btb_hit_i,
    input  logic                    IF_prediction_i,

    input  logic                    stall_i,
    input  logic                    flush_i,

    input  logic                    EX_is_br_i,
    input  logic [1:0]              EX_is_uncbr_i,
    input  logic                    EX_br_decision_i,
    input  logic [31:0]             EX_br_target_i,

    input  logic                    clr_cnt_i,

    output logic                    EXMEM_valid_o,
    output logic [INDEX_WIDTH-1:0]  EXMEM_btb_wr_index_o,
    output logic [29-INDEX_WIDTH:0] EXMEM_btb_wr_tag_o,
    output logic [31:0]             EXMEM_btb_wr_target_o,
    output logic                    EXMEM_btb_hit_o,
    output logic                    EXMEM_prediction_o,
    output logic                    EXMEM_br_decision_o,
    output logic                    EXMEM_is_br_o,
    output logic [1:0]              EXMEM_is_uncbr_o,

    output logic [31:0]             br_cnt_o,
    output logic [31:0]             mispred_cnt_o
);

    // PC is word aligned, so only pc[31:2] travels down the pipe.
    typedef struct packed {
        logic        valid;
        logic [29:0] pc_w;
        logic        btb_hit;
        logic        prediction;
    } stage_t;

    typedef struct packed {
        stage_t      meta;
        logic        is_br;
        logic [1:0]  is_uncbr;
        logic        br_decision;
        logic [31:0] br_target;
    } exmem_t;

    localparam logic [1:0] UNC_JAL  = 2'b10;
    localparam logic [1:0] UNC_JALR = 2'b11;

    stage_t ifid_q, ifid_d;
    stage_t idex_q, idex_d;
    stage_t fetch_s;
    exmem_t exmem_q, exmem_d;

    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    logic stall_hold;
    logic is_jal;
    logic is_jalr;
    logic commit_ev;
    logic mispred_ev;
    logic pc_lsb_unused;

    assign pc_lsb_unused = ^IF_pc_i[1:0];

    assign fetch_s.valid      = IF_valid_i;
    assign fetch_s.pc_w       = IF_pc_i[31:2];
    assign fetch_s.btb_hit    = IF_btb_hit_i;
    assign fetch_s.prediction = IF_prediction_i;

    // Flush dominates stall: the held IF/ID entry is wrong-path anyway.
    assign stall_hold = stall_i & ~flush_i;

    always_comb begin
        ifid_d  = stall_hold ? ifid_q : fetch_s;
        idex_d  = stall_hold ? '0 : ifid_q;

        exmem_d             = '0;
        exmem_d.meta        = idex_q;
        exmem_d.is_br       = EX_is_br_i;
        exmem_d.is_uncbr    = EX_is_uncbr_i;
        exmem_d.br_decision = EX_br_decision_i;
        exmem_d.br_target   = EX_br_target_i;

        // IF, ID and EX hold wrong-path work; the entry already in
        // EX/MEM is older than the redirect and still commits.
        if (flush_i) begin
            ifid_d.valid       = 1'b0;
            idex_d.valid       = 1'b0;
            exmem_d.meta.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    // Commit-stage events, evaluated on the registered entry.
    assign is_jal  = (exmem_q.is_uncbr == UNC_JAL);
    assign is_jalr = (exmem_q.is_uncbr == UNC_JALR);

    assign commit_ev = exmem_q.meta.valid
                     & (exmem_q.is_br | is_jal | is_jalr);

    // JALR always counts as mispredicted: the target is never predicted.
    assign mispred_ev = exmem_q.meta.valid
                      & ((((exmem_q.is_br | is_jal)
                          & (exmem_q.meta.prediction
                             != exmem_q.br_decision)))
                         | is_jalr);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (commit_ev && (br_cnt_q != '1))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (mispred_ev && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign EXMEM_valid_o         = exmem_q.meta.valid;
    assign EXMEM_btb_wr_index_o  = exmem_q.meta.pc_w[INDEX_WIDTH-1:0];
    assign EXMEM_btb_wr_tag_o    = exmem_q.meta.pc_w[29:INDEX_WIDTH];
    assign EXMEM_btb_wr_target_o = exmem_q.br_target;
    assign EXMEM_btb_hit_o       = exmem_q.meta.btb_hit;
    assign EXMEM_prediction_o    = exmem_q.meta.prediction;

    // Bubbles must never look like control transfers to the predictor.
    assign EXMEM_is_br_o       = exmem_q.meta.valid & exmem_q.is_br;
    assign EXMEM_is_uncbr_o    = exmem_q.meta.valid
                               ? exmem_q.is_uncbr : 2'b00;
    assign EXMEM_br_decision_o = exmem_q.meta.valid & exmem_q.br_decision;

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_br_commit_tracker.sv
// Directed bench for br_commit_tracker: pipeline latency, flush, stall,
// JAL/JALR accounting, counter saturation/clear and async reset.

module tb_br_commit_tracker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IF_valid_i;
    logic [31:0] IF_pc_i;
    logic        IF_btb_hit_i;
    logic        IF_prediction_i;
    logic        stall_i;
    logic        flush_i;
    logic        EX_is_br_i;
    logic [1:0]  EX_is_uncbr_i;
    logic        EX_br_decision_i;
    logic [31:0] EX_br_target_i;
    logic        clr_cnt_i;

    logic        EXMEM_valid_o;
    logic [11:0] EXMEM_btb_wr_index_o;
    logic [17:0] EXMEM_btb_wr_tag_o;
    logic [31:0] EXMEM_btb_wr_target_o;
    logic        EXMEM_btb_hit_o;
    logic        EXMEM_prediction_o;
    logic        EXMEM_br_decision_o;
    logic        EXMEM_is_br_o;
    logic [1:0]  EXMEM_is_uncbr_o;
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    br_commit_tracker #(.INDEX_WIDTH(12)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .IF_valid_i            (IF_valid_i),
        .IF_pc_i               (IF_pc_i),
        .IF_btb_hit_i          (IF_btb_hit_i),
        .IF_prediction_i       (IF_prediction_i),
        .stall_i               (stall_i),
        .flush_i               (flush_i),
        .EX_is_br_i            (EX_is_br_i),
        .EX_is_uncbr_i         (EX_is_uncbr_i),
        .EX_br_decision_i      (EX_br_decision_i),
        .EX_br_target_i        (EX_br_target_i),
        .clr_cnt_i             (clr_cnt_i),
        .EXMEM_valid_o         (EXMEM_valid_o),
        .EXMEM_btb_wr_index_o  (EXMEM_btb_wr_index_o),
        .EXMEM_btb_wr_tag_o    (EXMEM_btb_wr_tag_o),
        .EXMEM_btb_wr_target_o (EXMEM_btb_wr_target_o),
        .EXMEM_btb_hit_o       (EXMEM_btb_hit_o),
        .EXMEM_prediction_o    (EXMEM_prediction_o),
        .EXMEM_br_decision_o   (EXMEM_br_decision_o),
        .EXMEM_is_br_o         (EXMEM_is_br_o),
        .EXMEM_is_uncbr_o      (EXMEM_is_uncbr_o),
        .br_cnt_o              (br_cnt_o),
        .mispred_cnt_o         (mispred_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc,
                          input logic hit, input logic pred);
        IF_valid_i      = v;
        IF_pc_i         = pc;
        IF_btb_hit_i    = hit;
        IF_prediction_i = pred;
    endtask

    task automatic set_ex(input logic br, input logic [1:0] unc,
                          input logic dec, input logic [31:0] tgt);
        EX_is_br_i       = br;
        EX_is_uncbr_i    = unc;
        EX_br_decision_i = dec;
        EX_br_target_i   = tgt;
    endtask

    initial begin
        rst_i     = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        clr_cnt_i = 1'b0;
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);

        // reset state
        step();
        chk("rst_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("rst_br_cnt", br_cnt_o, 32'd0);
        chk("rst_mp_cnt", mispred_cnt_o, 32'd0);
        chk("rst_target", EXMEM_btb_wr_target_o, 32'd0);
        rst_i = 1'b1;
        step();

        // correctly predicted taken branch, 3-cycle latency
        set_if(1'b1, 32'h0000_1008, 1'b1, 1'b1);
        step();
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("t1_early_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0000_2000);
        step();
        chk("t1_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        chk("t1_index", {20'd0, EXMEM_btb_wr_index_o}, 32'h402);
        chk("t1_tag", {14'd0, EXMEM_btb_wr_tag_o}, 32'h0);
        chk("t1_target", EXMEM_btb_wr_target_o, 32'h0000_2000);
        chk("t1_is_br", {31'd0, EXMEM_is_br_o}, 32'd1);
        chk("t1_hit", {31'd0, EXMEM_btb_hit_o}, 32'd1);
        chk("t1_pred", {31'd0, EXMEM_prediction_o}, 32'd1);
        chk("t1_dec", {31'd0, EXMEM_br_decision_o}, 32'd1);
        chk("t1_br_cnt_pre", br_cnt_o, 32'd0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0000_1234);
        step();
        chk("t1_bub_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("t1_bub_is_br", {31'd0, EXMEM_is_br_o}, 32'd0);
        chk("t1_bub_dec", {31'd0, EXMEM_br_decision_o}, 32'd0);
        chk("t1_br_cnt", br_cnt_o, 32'd1);
        chk("t1_mp_cnt", mispred_cnt_o, 32'd0);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);

        // mispredicted branch followed by a flush
        set_if(1'b1, 32'h0000_3004, 1'b1, 1'b0);
        step();
        set_if(1'b1, 32'h0000_3008, 1'b0, 1'b0);
        step();
        set_if(1'b1, 32'h0000_300C, 1'b0, 1'b0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0000_4000);
        step();
        chk("t2_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        chk("t2_pred", {31'd0, EXMEM_prediction_o}, 32'd0);
        set_if(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("t2_fl0_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("t2_br_cnt", br_cnt_o, 32'd2);
        chk("t2_mp_cnt", mispred_cnt_o, 32'd1);
        set_if(1'b1, 32'h0000_4000, 1'b0, 1'b0);
        set_ex(1'b1, 2'b11, 1'b1, 32'h0000_5555);
        step();
        chk("t2_fl1_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("t2_fl1_is_br", {31'd0, EXMEM_is_br_o}, 32'd0);
        chk("t2_fl1_uncbr", {30'd0, EXMEM_is_uncbr_o}, 32'd0);
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0);
        step();
        chk("t2_fl2_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("t2_fl2_is_br", {31'd0, EXMEM_is_br_o}, 32'd0);
        chk("t2_fl2_br_cnt", br_cnt_o, 32'd2);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0000_4004);
        step();
        chk("t2_new_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        chk("t2_new_index", {20'd0, EXMEM_btb_wr_index_o}, 32'h000);
        chk("t2_new_tag", {14'd0, EXMEM_btb_wr_tag_o}, 32'h1);
        chk("t2_new_is_br", {31'd0, EXMEM_is_br_o}, 32'd0);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);
        step();
        chk("t2_end_br_cnt", br_cnt_o, 32'd2);
        chk("t2_end_mp_cnt", mispred_cnt_o, 32'd1);

        // JALR, JAL, and a non-transfer uncbr code 01
        set_if(1'b1, 32'h0000_5000, 1'b0, 1'b0);
        step();
        set_if(1'b1, 32'h0000_5004, 1'b1, 1'b1);
        step();
        set_if(1'b1, 32'h0000_5008, 1'b0, 1'b0);
        set_ex(1'b0, 2'b11, 1'b1, 32'h0000_6000);
        step();
        chk("t3_jalr_uncbr", {30'd0, EXMEM_is_uncbr_o}, 32'd3);
        chk("t3_jalr_target", EXMEM_btb_wr_target_o, 32'h0000_6000);
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        set_ex(1'b0, 2'b10, 1'b1, 32'h0000_7000);
        step();
        chk("t3_jalr_br_cnt", br_cnt_o, 32'd3);
        chk("t3_jalr_mp_cnt", mispred_cnt_o, 32'd2);
        chk("t3_jal_uncbr", {30'd0, EXMEM_is_uncbr_o}, 32'd2);
        set_ex(1'b0, 2'b01, 1'b0, 32'h0);
        step();
        chk("t3_jal_br_cnt", br_cnt_o, 32'd4);
        chk("t3_jal_mp_cnt", mispred_cnt_o, 32'd2);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);
        step();
        chk("t3_u01_br_cnt", br_cnt_o, 32'd4);
        chk("t3_u01_mp_cnt", mispred_cnt_o, 32'd2);

        // two-cycle stall with branch held in IF/ID
        set_if(1'b1, 32'h0000_8010, 1'b1, 1'b1);
        step();
        set_if(1'b1, 32'h0000_9000, 1'b0, 1'b0);
        stall_i = 1'b1;
        step();
        step();
        chk("t4_st_valid0", {31'd0, EXMEM_valid_o}, 32'd0);
        stall_i = 1'b0;
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("t4_st_valid1", {31'd0, EXMEM_valid_o}, 32'd0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0000_8800);
        step();
        chk("t4_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        chk("t4_index", {20'd0, EXMEM_btb_wr_index_o}, 32'h004);
        chk("t4_tag", {14'd0, EXMEM_btb_wr_tag_o}, 32'h2);
        chk("t4_target", EXMEM_btb_wr_target_o, 32'h0000_8800);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);
        step();
        chk("t4_single", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("t4_br_cnt", br_cnt_o, 32'd5);
        chk("t4_mp_cnt", mispred_cnt_o, 32'd2);

        // saturation from a backdoor preload, then clear over a commit
        dut.br_cnt_q      = 32'hFFFF_FFFE;
        dut.mispred_cnt_q = 32'hFFFF_FFFE;
        set_if(1'b1, 32'h0000_A000, 1'b1, 1'b0);
        step();
        set_if(1'b1, 32'h0000_A004, 1'b1, 1'b0);
        step();
        set_if(1'b1, 32'h0000_A008, 1'b1, 1'b0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0000_B000);
        step();
        chk("t5_pre_br_cnt", br_cnt_o, 32'hFFFF_FFFE);
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("t5_br_cnt_1", br_cnt_o, 32'hFFFF_FFFF);
        chk("t5_mp_cnt_1", mispred_cnt_o, 32'hFFFF_FFFF);
        step();
        chk("t5_br_cnt_sat", br_cnt_o, 32'hFFFF_FFFF);
        chk("t5_mp_cnt_sat", mispred_cnt_o, 32'hFFFF_FFFF);
        chk("t5_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        chk("t5_clr_br_cnt", br_cnt_o, 32'd0);
        chk("t5_clr_mp_cnt", mispred_cnt_o, 32'd0);
        step();
        chk("t5_post_br_cnt", br_cnt_o, 32'd0);

        // async reset mid-stream, then restart latency
        set_if(1'b1, 32'h0000_C00C, 1'b1, 1'b1);
        step();
        set_if(1'b1, 32'h0000_C010, 1'b0, 1'b0);
        step();
        set_if(1'b1, 32'h0000_C014, 1'b1, 1'b0);
        set_ex(1'b1, 2'b00, 1'b1, 32'h0000_D000);
        step();
        chk("t6_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        set_if(1'b1, 32'h0000_C018, 1'b1, 1'b1);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0000_D004);
        step();
        chk("t6_br_cnt", br_cnt_o, 32'd1);
        chk("t6_pre_rst_valid", {31'd0, EXMEM_valid_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_ar_valid", {31'd0, EXMEM_valid_o}, 32'd0);
        chk("t6_ar_br_cnt", br_cnt_o, 32'd0);
        chk("t6_ar_target", EXMEM_btb_wr_target_o, 32'd0);
        chk("t6_ar_index", {20'd0, EXMEM_btb_wr_index_o}, 32'd0);
        chk("t6_ar_tag", {14'd0, EXMEM_btb_wr_tag_o}, 32'd0);
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        set_ex(1'b0, 2'b00, 1'b0, 32'h0);
        step();
        rst_i = 1'b1;
        step();
        chk("t6_drain0", {31'd0, EXMEM_valid_o}, 32'd0);
        step();
        chk("t6_drain1", {31'd0, EXMEM_valid_o}, 32'd0);
        step();
        chk("t6_drain2", {31'd0, EXMEM_valid_o}, 32'd0);
        set_if(1'b1, 32'h0000_E000, 1'b1, 1'b1);
        step();
        set_if(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("t6_lat2", {31'd0, EXMEM_valid_o}, 32'd0);
        step();
        chk("t6_lat3", {31'd0, EXMEM_valid_o}, 32'd1);
        chk("t6_index", {20'd0, EXMEM_btb_wr_index_o}, 32'h800);
        chk("t6_tag", {14'd0, EXMEM_btb_wr_tag_o}, 32'h3);
        chk("t6_cnt", mispred_cnt_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
